// File: rtl/adc_spi_pkg.sv
// Shared definitions for the dual-ADC SPI configuration port: FSM encoding,
// frame geometry and the frame builder.
package adc_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } spi_state_t;

    localparam int FRAME_W  = 24;
    localparam int RW_BIT   = 23;
    localparam int ADDR_MSB = 20;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;
    localparam int TURN_BIT = 8;

    // Reads carry a zero data field; the ADC drives those bit slots instead.
    function automatic logic [FRAME_W-1:0] build_frame(input logic        rw,
                                                       input logic [12:0] addr,
                                                       input logic [7:0]  wdata);
        logic [FRAME_W-1:0] f;
        f = '0;
        f[RW_BIT]            = rw;
        f[ADDR_MSB:ADDR_LSB] = addr;
        f[DATA_MSB:DATA_LSB] = rw ? 8'h00 : wdata;
        return f;
    endfunction

endpackage

// File: rtl/adc_spi_config_clk_div_tick.sv
// Half-period timer: down-counter that emits a one-cycle tick every DIV
// enabled cycles; clr restarts the period so the first tick is DIV cycles out.
module clk_div_tick #(
    parameter int DIV = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [7:0] RELOAD = 8'(DIV - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= RELOAD;
        end else if (en) begin
            if (cnt == 8'd0) cnt <= RELOAD;
            else             cnt <= cnt - 8'd1;
        end
    end

    assign tick = en && (cnt == 8'd0);

endmodule

// File: rtl/adc_spi_config.sv
// 3-wire SPI master that writes/reads configuration registers of two ADCs
// sharing SCLK/SDIO, with separate active-low chip selects.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | pins at idle levels, waiting for an accepted start
// ST_SETUP | CSB low, SCLK low, bit 23 on SDIO for one half-period
// ST_SHIFT | 24 bits, each SCLK high half then low half
// ST_GAP   | CSB high, idle pin levels for two half-periods
module adc_spi_config
    import adc_spi_pkg::*;
#(
    parameter int   CLK_DIV   = 5,
    parameter logic IDLE_SCLK = 1'b1,
    parameter logic IDLE_SDIO = 1'b0
) (
    input  logic        i_clock,
    input  logic        i_RESET,
    input  logic        i_start,
    input  logic        i_rw,
    input  logic [1:0]  i_sel,
    input  logic [12:0] i_addr,
    input  logic [7:0]  i_wdata,
    input  logic        i_sdio,
    output logic        o_sclk,
    output logic        o_sdio,
    output logic        o_sdio_oe,
    output logic        o_csb_a,
    output logic        o_csb_b,
    output logic        o_busy,
    output logic        o_done,
    output logic [7:0]  o_rdata
);

    localparam logic [4:0] FIRST_IDX = 5'(RW_BIT);
    localparam logic [4:0] TURN_IDX  = 5'(TURN_BIT);

    spi_state_t         state;
    logic [FRAME_W-1:0] frame;
    logic               rw_q;
    logic [4:0]         bit_idx;
    logic               phase_low;
    logic [7:0]         rx_shift;
    logic [1:0]         sdio_sync;
    logic               accept;
    logic               tick;

    // Reading from both ADCs at once would short their SDIO drivers.
    assign accept = (state == ST_IDLE) && i_start && (i_sel != 2'b00) &&
                    !(i_rw && (i_sel == 2'b11));

    clk_div_tick #(.DIV(CLK_DIV)) u_tick (
        .clk  (i_clock),
        .rst  (i_RESET),
        .en   (state != ST_IDLE),
        .clr  (accept),
        .tick (tick)
    );

    always_ff @(posedge i_clock or posedge i_RESET) begin
        if (i_RESET) sdio_sync <= '0;
        else         sdio_sync <= {sdio_sync[0], i_sdio};
    end

    always_ff @(posedge i_clock or posedge i_RESET) begin
        if (i_RESET) begin
            state     <= ST_IDLE;
            frame     <= '0;
            rw_q      <= 1'b0;
            bit_idx   <= '0;
            phase_low <= 1'b0;
            rx_shift  <= '0;
            o_sclk    <= IDLE_SCLK;
            o_sdio    <= IDLE_SDIO;
            o_sdio_oe <= 1'b1;
            o_csb_a   <= 1'b1;
            o_csb_b   <= 1'b1;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_rdata   <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_SETUP;
                        frame     <= build_frame(i_rw, i_addr, i_wdata);
                        rw_q      <= i_rw;
                        bit_idx   <= FIRST_IDX;
                        phase_low <= 1'b0;
                        o_busy    <= 1'b1;
                        o_sclk    <= 1'b0;
                        o_sdio    <= i_rw;
                        o_sdio_oe <= 1'b1;
                        o_csb_a   <= ~i_sel[0];
                        o_csb_b   <= ~i_sel[1];
                    end
                end
                ST_SETUP: begin
                    if (tick) begin
                        state     <= ST_SHIFT;
                        phase_low <= 1'b0;
                        o_sclk    <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        if (!phase_low) begin
                            // Falling edge: present the next bit, release SDIO
                            // after the header, capture read data before it.
                            phase_low <= 1'b1;
                            o_sclk    <= 1'b0;
                            if (bit_idx != 5'd0)
                                o_sdio <= frame[bit_idx - 5'd1];
                            if (rw_q && (bit_idx == TURN_IDX))
                                o_sdio_oe <= 1'b0;
                            if (rw_q && (bit_idx < TURN_IDX))
                                rx_shift <= {rx_shift[6:0], sdio_sync[1]};
                        end else if (bit_idx == 5'd0) begin
                            state     <= ST_GAP;
                            phase_low <= 1'b0;
                            o_csb_a   <= 1'b1;
                            o_csb_b   <= 1'b1;
                            o_sclk    <= IDLE_SCLK;
                            o_sdio    <= IDLE_SDIO;
                            o_sdio_oe <= 1'b1;
                        end else begin
                            bit_idx   <= bit_idx - 5'd1;
                            phase_low <= 1'b0;
                            o_sclk    <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        if (!phase_low) begin
                            phase_low <= 1'b1;
                        end else begin
                            state     <= ST_IDLE;
                            phase_low <= 1'b0;
                            o_busy    <= 1'b0;
                            o_done    <= 1'b1;
                            if (rw_q) o_rdata <= rx_shift;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_config.sv
// Directed bench for adc_spi_config at CLK_DIV=5 with a behavioural ADC
// responder driving SDIO during the read data bits.
module tb_adc_spi_config;

    logic        i_clock = 1'b0;
    logic        i_RESET;
    logic        i_start;
    logic        i_rw;
    logic [1:0]  i_sel;
    logic [12:0] i_addr;
    logic [7:0]  i_wdata;
    logic        i_sdio;
    logic        o_sclk, o_sdio, o_sdio_oe, o_csb_a, o_csb_b, o_busy, o_done;
    logic [7:0]  o_rdata;

    adc_spi_config dut (
        .i_clock   (i_clock),
        .i_RESET   (i_RESET),
        .i_start   (i_start),
        .i_rw      (i_rw),
        .i_sel     (i_sel),
        .i_addr    (i_addr),
        .i_wdata   (i_wdata),
        .i_sdio    (i_sdio),
        .o_sclk    (o_sclk),
        .o_sdio    (o_sdio),
        .o_sdio_oe (o_sdio_oe),
        .o_csb_a   (o_csb_a),
        .o_csb_b   (o_csb_b),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_rdata   (o_rdata)
    );

    always #5 i_clock = ~i_clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus-side controls, written only by the test tasks.
    int         clr_req = 0;
    int         acc_cyc = 0;
    logic [7:0] resp_byte = 8'h00;

    // Monitor/responder state, written only by the negedge process.
    int          ncyc = 0;
    int          clr_seen = 0;
    int          csb_a_lo = 0, csb_b_lo = 0, both_lo = 0, busy_cnt = 0;
    int          done_cnt = 0, done_rel_first = 0, done_rel_last = 0;
    int          rise_cnt = 0, oe_lo = 0, oe_lo_rise = 0, frame_falls = 0;
    logic [47:0] cap = '0;
    logic [7:0]  done_rdata = 8'h00, pre_done_rdata = 8'h00, prev_rdata = 8'h00;
    logic        prev_sclk = 1'b1, prev_csb_lo = 1'b0, mon_csb_lo;

    always @(negedge i_clock) begin
        ncyc = ncyc + 1;
        if (clr_req != clr_seen) begin
            clr_seen = clr_req;
            csb_a_lo = 0; csb_b_lo = 0; both_lo = 0; busy_cnt = 0;
            done_cnt = 0; done_rel_first = 0; done_rel_last = 0;
            rise_cnt = 0; oe_lo = 0; oe_lo_rise = 0; cap = '0;
        end
        mon_csb_lo = !o_csb_a || !o_csb_b;
        if (!o_csb_a) csb_a_lo++;
        if (!o_csb_b) csb_b_lo++;
        if (!o_csb_a && !o_csb_b) both_lo++;
        if (o_busy) busy_cnt++;
        if (!o_sdio_oe) oe_lo++;
        if (o_done) begin
            done_cnt++;
            if (done_cnt == 1) done_rel_first = ncyc - acc_cyc;
            done_rel_last  = ncyc - acc_cyc;
            done_rdata     = o_rdata;
            pre_done_rdata = prev_rdata;
        end
        if (mon_csb_lo && !prev_sclk && o_sclk) begin
            rise_cnt++;
            cap = {cap[46:0], o_sdio};
            if (!o_sdio_oe) oe_lo_rise++;
        end
        // ADC model: after the fall ending bit n it drives read bit n-1.
        if (!mon_csb_lo) begin
            frame_falls = 0;
            i_sdio = 1'b0;
        end else if (prev_csb_lo && prev_sclk && !o_sclk) begin
            frame_falls++;
            if (frame_falls >= 16 && frame_falls <= 23)
                i_sdio = resp_byte[23 - frame_falls];
        end
        prev_sclk   = o_sclk;
        prev_csb_lo = mon_csb_lo;
        prev_rdata  = o_rdata;
    end

    task automatic clear_mon();
        clr_req++;
        @(negedge i_clock);
    endtask

    task automatic start_frame(input logic rw, input logic [1:0] sel,
                               input logic [12:0] addr, input logic [7:0] wdata);
        @(posedge i_clock); #1;
        i_rw = rw; i_sel = sel; i_addr = addr; i_wdata = wdata; i_start = 1'b1;
        @(posedge i_clock); #1;
        acc_cyc = ncyc;
        i_start = 1'b0; i_rw = ~rw; i_sel = 2'b11; i_addr = ~addr; i_wdata = ~wdata;
    endtask

    task automatic wait_done(input int target, input int max_cyc);
        int n = 0;
        while (done_cnt < target && n < max_cyc) begin
            @(negedge i_clock);
            n++;
        end
        repeat (20) @(negedge i_clock);
    endtask

    task automatic test_reset();
        i_RESET = 1'b1; i_start = 1'b0; i_rw = 1'b0; i_sel = 2'b00;
        i_addr = '0; i_wdata = '0;
        repeat (3) @(posedge i_clock);
        #1 i_RESET = 1'b0;
        @(negedge i_clock);
        n_checks++;
        if ({o_csb_a, o_csb_b, o_sclk, o_sdio, o_sdio_oe, o_busy, o_done} !== 7'b1110100) begin
            n_fail++;
            $display("FAIL reset_pins: got %b expected %b",
                     {o_csb_a, o_csb_b, o_sclk, o_sdio, o_sdio_oe, o_busy, o_done}, 7'b1110100);
        end
        n_checks++;
        if (o_rdata !== 8'h00) begin
            n_fail++; $display("FAIL reset_rdata: got %h expected 00", o_rdata);
        end
    endtask

    task automatic test_write();
        clear_mon();
        start_frame(1'b0, 2'b01, 13'h0014, 8'h01);
        wait_done(1, 400);
        n_checks++;
        if (cap[23:0] !== 24'h001401) begin
            n_fail++; $display("FAIL write_frame: got %h expected 001401", cap[23:0]);
        end
        n_checks++;
        if (rise_cnt !== 24) begin
            n_fail++; $display("FAIL write_rises: got %0d expected 24", rise_cnt);
        end
        n_checks++;
        if (csb_a_lo !== 245 || csb_b_lo !== 0) begin
            n_fail++; $display("FAIL write_csb: got a=%0d b=%0d expected a=245 b=0", csb_a_lo, csb_b_lo);
        end
        n_checks++;
        if (busy_cnt !== 255) begin
            n_fail++; $display("FAIL write_busy: got %0d expected 255", busy_cnt);
        end
        n_checks++;
        if (done_cnt !== 1 || done_rel_first !== 256) begin
            n_fail++; $display("FAIL write_done: got count=%0d at=%0d expected count=1 at=256", done_cnt, done_rel_first);
        end
        n_checks++;
        if (o_rdata !== 8'h00) begin
            n_fail++; $display("FAIL write_rdata: got %h expected 00", o_rdata);
        end
        n_checks++;
        if ({o_csb_a, o_csb_b, o_sclk, o_sdio, o_sdio_oe, o_busy} !== 6'b111010) begin
            n_fail++; $display("FAIL write_idle: got %b expected 111010",
                               {o_csb_a, o_csb_b, o_sclk, o_sdio, o_sdio_oe, o_busy});
        end
    endtask

    task automatic test_read();
        clear_mon();
        resp_byte = 8'h09;
        start_frame(1'b1, 2'b10, 13'h0001, 8'hEE);
        wait_done(1, 400);
        n_checks++;
        if (cap[23:8] !== 16'h8001) begin
            n_fail++; $display("FAIL read_header: got %h expected 8001", cap[23:8]);
        end
        n_checks++;
        if (csb_b_lo !== 245 || csb_a_lo !== 0) begin
            n_fail++; $display("FAIL read_csb: got a=%0d b=%0d expected a=0 b=245", csb_a_lo, csb_b_lo);
        end
        n_checks++;
        if (oe_lo !== 85 || oe_lo_rise !== 8) begin
            n_fail++; $display("FAIL read_oe: got cycles=%0d rises=%0d expected 85 and 8", oe_lo, oe_lo_rise);
        end
        n_checks++;
        if (pre_done_rdata !== 8'h00 || done_rdata !== 8'h09) begin
            n_fail++; $display("FAIL read_load: got before=%h at_done=%h expected 00 and 09", pre_done_rdata, done_rdata);
        end
        n_checks++;
        if (o_rdata !== 8'h09 || done_cnt !== 1) begin
            n_fail++; $display("FAIL read_rdata: got %h done=%0d expected 09 done=1", o_rdata, done_cnt);
        end
    endtask

    task automatic test_ignored_start();
        clear_mon();
        start_frame(1'b0, 2'b01, 13'h1ABC, 8'h5A);
        repeat (100) @(negedge i_clock);
        @(posedge i_clock); #1;
        i_rw = 1'b0; i_sel = 2'b10; i_addr = 13'h0000; i_wdata = 8'hFF; i_start = 1'b1;
        @(posedge i_clock); #1;
        i_start = 1'b0;
        wait_done(1, 400);
        n_checks++;
        if (cap[23:0] !== 24'h1ABC5A) begin
            n_fail++; $display("FAIL ignored_frame: got %h expected 1abc5a", cap[23:0]);
        end
        n_checks++;
        if (done_cnt !== 1 || busy_cnt !== 255 || csb_b_lo !== 0) begin
            n_fail++; $display("FAIL ignored_single: got done=%0d busy=%0d csb_b=%0d expected 1 255 0",
                               done_cnt, busy_cnt, csb_b_lo);
        end
        n_checks++;
        if (o_rdata !== 8'h09) begin
            n_fail++; $display("FAIL ignored_rdata: got %h expected 09", o_rdata);
        end
    endtask

    task automatic test_sel_rules();
        clear_mon();
        start_frame(1'b1, 2'b11, 13'h0005, 8'h00);
        repeat (30) @(negedge i_clock);
        start_frame(1'b0, 2'b00, 13'h0005, 8'h33);
        repeat (30) @(negedge i_clock);
        start_frame(1'b1, 2'b00, 13'h0005, 8'h00);
        repeat (30) @(negedge i_clock);
        n_checks++;
        if (busy_cnt !== 0 || done_cnt !== 0) begin
            n_fail++; $display("FAIL sel_ignored: got busy=%0d done=%0d expected 0 0", busy_cnt, done_cnt);
        end
        n_checks++;
        if (csb_a_lo + csb_b_lo !== 0 || rise_cnt !== 0) begin
            n_fail++; $display("FAIL sel_quiet: got csb=%0d rises=%0d expected 0 0", csb_a_lo + csb_b_lo, rise_cnt);
        end
        clear_mon();
        start_frame(1'b0, 2'b11, 13'h00FF, 8'hA5);
        wait_done(1, 400);
        n_checks++;
        if (both_lo !== 245 || csb_a_lo !== 245 || csb_b_lo !== 245) begin
            n_fail++; $display("FAIL sel_both: got both=%0d a=%0d b=%0d expected 245", both_lo, csb_a_lo, csb_b_lo);
        end
        n_checks++;
        if (cap[23:0] !== 24'h00FFA5 || done_cnt !== 1) begin
            n_fail++; $display("FAIL sel_both_frame: got %h done=%0d expected 00ffa5 done=1", cap[23:0], done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        clear_mon();
        resp_byte = 8'hC3;
        start_frame(1'b0, 2'b01, 13'h0002, 8'h3C);
        while (!o_done && n < 400) begin
            @(negedge i_clock);
            n++;
        end
        i_rw = 1'b1; i_sel = 2'b01; i_addr = 13'h1FFF; i_wdata = 8'h00; i_start = 1'b1;
        @(posedge i_clock); #1;
        i_start = 1'b0;
        wait_done(2, 400);
        n_checks++;
        if (done_cnt !== 2 || done_rel_first !== 256 || done_rel_last !== 512) begin
            n_fail++; $display("FAIL b2b_done: got count=%0d first=%0d last=%0d expected 2 256 512",
                               done_cnt, done_rel_first, done_rel_last);
        end
        n_checks++;
        if (busy_cnt !== 510) begin
            n_fail++; $display("FAIL b2b_busy: got %0d expected 510", busy_cnt);
        end
        n_checks++;
        if (cap[47:24] !== 24'h00023C || cap[23:8] !== 16'h9FFF || rise_cnt !== 48) begin
            n_fail++; $display("FAIL b2b_frames: got %h/%h rises=%0d expected 00023c/9fff rises=48",
                               cap[47:24], cap[23:8], rise_cnt);
        end
        n_checks++;
        if (o_rdata !== 8'hC3) begin
            n_fail++; $display("FAIL b2b_rdata: got %h expected c3", o_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_mon();
        start_frame(1'b0, 2'b01, 13'h0123, 8'h77);
        while (rise_cnt < 14 && n < 400) begin
            @(negedge i_clock);
            n++;
        end
        n_checks++;
        if (rise_cnt !== 14 || o_csb_a !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_reach: got rises=%0d csb_a=%b expected 14 0", rise_cnt, o_csb_a);
        end
        #1 i_RESET = 1'b1;
        #1;
        n_checks++;
        if ({o_csb_a, o_csb_b, o_sclk, o_sdio, o_sdio_oe, o_busy, o_done} !== 7'b1110100 || o_rdata !== 8'h00) begin
            n_fail++; $display("FAIL rst_mid_immediate: got %b rdata=%h expected 1110100 rdata=00",
                               {o_csb_a, o_csb_b, o_sclk, o_sdio, o_sdio_oe, o_busy, o_done}, o_rdata);
        end
        @(posedge i_clock); #1;
        i_RESET = 1'b0;
        repeat (300) @(negedge i_clock);
        n_checks++;
        if (done_cnt !== 0) begin
            n_fail++; $display("FAIL rst_mid_nodone: got %0d expected 0", done_cnt);
        end
        clear_mon();
        start_frame(1'b0, 2'b01, 13'h0014, 8'h01);
        wait_done(1, 400);
        n_checks++;
        if (cap[23:0] !== 24'h001401 || done_cnt !== 1 || done_rel_first !== 256) begin
            n_fail++; $display("FAIL rst_mid_recover: got %h done=%0d at=%0d expected 001401 1 256",
                               cap[23:0], done_cnt, done_rel_first);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_ignored_start();
        test_sel_rules();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
